// File: rtl/seven_seg_display.sv
// seven_seg_display: binary-to-BCD converter plus 6-digit multiplexed 7-segment scanner (HH.MM.SS).
// Defining DISPLAY_BUZZER_EN builds the blink-gated alarm/timer buzzer; otherwise buzzer is tied low.

`ifndef KILO
`define KILO 1000
`endif
`ifndef SELECT_NONE
`define SELECT_NONE 2'd0
`endif
`ifndef SELECT_SEC
`define SELECT_SEC 2'd1
`endif
`ifndef SELECT_MIN
`define SELECT_MIN 2'd2
`endif
`ifndef SELECT_HOUR
`define SELECT_HOUR 2'd3
`endif

module seven_seg_display #(
  parameter int CLK_FREQ_HZ = `KILO,
  parameter int DIGIT_HZ    = 500,
  parameter int BLINK_HZ    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic [4:0] hour_in,
  input  logic [1:0] select,
  input  logic       alarm_in,
  input  logic       timer_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] digit_en,
  output logic       buzzer
);

  localparam int DIG_DIV = CLK_FREQ_HZ / DIGIT_HZ;
  localparam int BLK_DIV = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int DIG_W   = (DIG_DIV > 1) ? $clog2(DIG_DIV) : 1;
  localparam int BLK_W   = (BLK_DIV > 1) ? $clog2(BLK_DIV) : 1;
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIG_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLK_DIV - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CONV_SEC  = 3'd1;
  localparam logic [2:0] ST_CONV_MIN  = 3'd2;
  localparam logic [2:0] ST_CONV_HOUR = 3'd3;
  localparam logic [2:0] ST_COMMIT    = 3'd4;

  logic [2:0] state_q, state_d;
  logic [5:0] secWork_q, secWork_d, minWork_q, minWork_d;
  logic [4:0] hourWork_q, hourWork_d;
  logic [3:0] secAcc_q, secAcc_d, minAcc_q, minAcc_d, hourAcc_q, hourAcc_d;
  logic [3:0] secOnes_q, secOnes_d, secTens_q, secTens_d;
  logic [3:0] minOnes_q, minOnes_d, minTens_q, minTens_d;
  logic [3:0] hourOnes_q, hourOnes_d, hourTens_q, hourTens_d;

  logic [DIG_W-1:0] scanCnt_q, scanCnt_d;
  logic [BLK_W-1:0] blinkCnt_q, blinkCnt_d;
  logic [2:0] digitIdx_q, digitIdx_d;
  logic       blinkPhase_q, blinkPhase_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [5:0] digitEn_q, digitEn_d;
  logic       scanWrap, blank;
  logic [3:0] digitVal;
  logic [1:0] digitField;

  function automatic logic [6:0] segCode(input logic [3:0] v);
    case (v)
      4'd0:    segCode = 7'h3F;
      4'd1:    segCode = 7'h06;
      4'd2:    segCode = 7'h5B;
      4'd3:    segCode = 7'h4F;
      4'd4:    segCode = 7'h66;
      4'd5:    segCode = 7'h6D;
      4'd6:    segCode = 7'h7D;
      4'd7:    segCode = 7'h07;
      4'd8:    segCode = 7'h7F;
      4'd9:    segCode = 7'h6F;
      default: segCode = 7'h00;
    endcase
  endfunction

  // Repeated-subtraction converter; the six display digits only change together in COMMIT.
  always_comb begin
    state_d    = state_q;
    secWork_d  = secWork_q;
    minWork_d  = minWork_q;
    hourWork_d = hourWork_q;
    secAcc_d   = secAcc_q;
    minAcc_d   = minAcc_q;
    hourAcc_d  = hourAcc_q;
    secOnes_d  = secOnes_q;
    secTens_d  = secTens_q;
    minOnes_d  = minOnes_q;
    minTens_d  = minTens_q;
    hourOnes_d = hourOnes_q;
    hourTens_d = hourTens_q;
    case (state_q)
      ST_IDLE: begin
        secWork_d  = sec_in;
        minWork_d  = min_in;
        hourWork_d = hour_in;
        secAcc_d   = 4'd0;
        minAcc_d   = 4'd0;
        hourAcc_d  = 4'd0;
        state_d    = ST_CONV_SEC;
      end
      ST_CONV_SEC: begin
        if (secWork_q >= 6'd10) begin
          secWork_d = secWork_q - 6'd10;
          secAcc_d  = secAcc_q + 4'd1;
        end else begin
          state_d = ST_CONV_MIN;
        end
      end
      ST_CONV_MIN: begin
        if (minWork_q >= 6'd10) begin
          minWork_d = minWork_q - 6'd10;
          minAcc_d  = minAcc_q + 4'd1;
        end else begin
          state_d = ST_CONV_HOUR;
        end
      end
      ST_CONV_HOUR: begin
        if (hourWork_q >= 5'd10) begin
          hourWork_d = hourWork_q - 5'd10;
          hourAcc_d  = hourAcc_q + 4'd1;
        end else begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        secOnes_d  = secWork_q[3:0];
        secTens_d  = secAcc_q;
        minOnes_d  = minWork_q[3:0];
        minTens_d  = minAcc_q;
        hourOnes_d = hourWork_q[3:0];
        hourTens_d = hourAcc_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The digit being loaded reads the *_d digits so a COMMIT on the same edge is shown at once.
  always_comb begin
    scanWrap   = (scanCnt_q == DIG_LAST);
    scanCnt_d  = scanWrap ? '0 : scanCnt_q + DIG_W'(1);
    blinkCnt_d = (blinkCnt_q == BLK_LAST) ? '0 : blinkCnt_q + BLK_W'(1);
    blinkPhase_d = (blinkCnt_q == BLK_LAST) ? ~blinkPhase_q : blinkPhase_q;
    digitIdx_d = digitIdx_q;
    if (scanWrap) begin
      digitIdx_d = (digitIdx_q == 3'd5) ? 3'd0 : digitIdx_q + 3'd1;
    end
    digitVal   = 4'd0;
    digitField = `SELECT_NONE;
    case (digitIdx_d)
      3'd0:    begin digitVal = secOnes_d;  digitField = `SELECT_SEC;  end
      3'd1:    begin digitVal = secTens_d;  digitField = `SELECT_SEC;  end
      3'd2:    begin digitVal = minOnes_d;  digitField = `SELECT_MIN;  end
      3'd3:    begin digitVal = minTens_d;  digitField = `SELECT_MIN;  end
      3'd4:    begin digitVal = hourOnes_d; digitField = `SELECT_HOUR; end
      default: begin digitVal = hourTens_d; digitField = `SELECT_HOUR; end
    endcase
    blank     = (select == digitField) && !blinkPhase_q;
    seg_d     = seg_q;
    dp_d      = dp_q;
    digitEn_d = digitEn_q;
    if (scanWrap) begin
      digitEn_d = 6'd1 << digitIdx_d;
      seg_d     = blank ? 7'h00 : segCode(digitVal);
      dp_d      = !blank && ((digitIdx_d == 3'd2) || (digitIdx_d == 3'd4));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      secWork_q  <= '0;
      minWork_q  <= '0;
      hourWork_q <= '0;
      secAcc_q   <= '0;
      minAcc_q   <= '0;
      hourAcc_q  <= '0;
      secOnes_q  <= '0;
      secTens_q  <= '0;
      minOnes_q  <= '0;
      minTens_q  <= '0;
      hourOnes_q <= '0;
      hourTens_q <= '0;
    end else begin
      state_q    <= state_d;
      secWork_q  <= secWork_d;
      minWork_q  <= minWork_d;
      hourWork_q <= hourWork_d;
      secAcc_q   <= secAcc_d;
      minAcc_q   <= minAcc_d;
      hourAcc_q  <= hourAcc_d;
      secOnes_q  <= secOnes_d;
      secTens_q  <= secTens_d;
      minOnes_q  <= minOnes_d;
      minTens_q  <= minTens_d;
      hourOnes_q <= hourOnes_d;
      hourTens_q <= hourTens_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scanCnt_q    <= '0;
      blinkCnt_q   <= '0;
      digitIdx_q   <= 3'd0;
      blinkPhase_q <= 1'b1;
      seg_q        <= 7'h00;
      dp_q         <= 1'b0;
      digitEn_q    <= 6'b000001;
    end else begin
      scanCnt_q    <= scanCnt_d;
      blinkCnt_q   <= blinkCnt_d;
      digitIdx_q   <= digitIdx_d;
      blinkPhase_q <= blinkPhase_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      digitEn_q    <= digitEn_d;
    end
  end

  assign seg      = seg_q;
  assign dp       = dp_q;
  assign digit_en = digitEn_q;

`ifdef DISPLAY_BUZZER_EN
  logic buzzer_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buzzer_q <= 1'b0;
    end else begin
      buzzer_q <= blinkPhase_q & (alarm_in | timer_in);
    end
  end

  assign buzzer = buzzer_q;
`else
  logic unusedBuzzerIn;

  assign unusedBuzzerIn = alarm_in | timer_in;
  assign buzzer         = 1'b0;
`endif

endmodule
